heap_insert_issuer: RTL
=======================

// Module: heap_insert_issuer
// PURPOSE
//  Front-end initiator for the pipelined heap stage chain. Accepts insert and query requests,
//  tracks the heap element count, computes the insert path, and drives the level-1 stage
//  input bus. Paces issue to at most one op every 2 cycles, the stage acceptance rate.
//  Sits between the cm-sketch top-K update logic and heap level 1.
// PARAMETERS
//  CNT_SIZE     20  counter value width
//  ADDR_SIZE    28  address tag width
//  TOTAL_LEVEL  6   heap depth in levels; capacity CAP = 2**TOTAL_LEVEL-1 (63)
// PORTS
//  clk                 in   1            clock
//  rst_n               in   1            async active-low reset
//  in_valid            in   1            insert request valid
//  in_ready            out  1            insert accepted when in_valid&in_ready
//  in_cnt              in   CNT_SIZE     insert counter value
//  in_addr             in   ADDR_SIZE    insert address tag
//  query_req           in   1            level: request one query op
//  query_ack           out  1            1-cycle pulse: query accepted this cycle
//  clear               in   1            level: reset heap count to 0
//  valid_o             out  1            stage-1 op valid
//  opcode_o            out  1            0=insert, 1=query
//  wcnt_o              out  CNT_SIZE     insert value
//  waddr_o             out  ADDR_SIZE    insert tag
//  insert_path_o       out  TOTAL_LEVEL  1-based target node number (count+1)
//  index_o             out  TOTAL_LEVEL  node index in level 1; always 0
//  heap_element_cnt_o  out  TOTAL_LEVEL  heap count before this op
//  heap_count          out  TOTAL_LEVEL  current element count
//  full                out  1            heap_count == CAP
//  busy                out  1            op in flight or pipeline draining
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low. Reset clears all state;
//   every output resets to 0; in_ready resets to 1.
//  FSM: IDLE, HOLD. All stage-bus outputs are registered.
//  IDLE, priority clear > query > insert:
//   - clear=1: heap_count<=0; in_ready=0; query_ack=0; stay IDLE.
//   - else query_req=1: query_ack=1; in_ready=0; next cycle valid_o=1, opcode_o=0/1 as
//     decided = 1; wcnt_o/waddr_o=0; heap_element_cnt_o=heap_count; -> HOLD.
//   - else in_valid&!full: in_ready=1; next cycle valid_o=1, opcode_o=0, wcnt_o=in_cnt,
//     waddr_o=in_addr, heap_element_cnt_o=heap_count, insert_path_o=heap_count+1,
//     index_o=0; heap_count<=heap_count+1 on the same edge; -> HOLD.
//  HOLD: valid_o=1 this cycle only; in_ready=0; query_ack=0; -> IDLE unconditionally.
//  In IDLE, valid_o=0 and opcode_o=0. opcode_o is never 1 without valid_o, so a stage
//   cannot enter query by mistake. Payload outputs keep their last value.
//  Throughput: one op per 2 cycles max. Handshake at cycle T gives valid_o at T+1 and the
//   next handshake at T+2 at the earliest.
//  in_ready = (state==IDLE) & !clear & !query_req & !full. It is combinational.
//  Full: when heap_count==CAP, inserts stall (in_ready=0). Queries are still issued.
//   heap_count never exceeds CAP and never wraps.
//  Width: insert_path_o = heap_count+1, which is at most CAP, so it fits in TOTAL_LEVEL bits.
//  Drain: a counter loads 2*TOTAL_LEVEL on every valid_o cycle and decrements to 0.
//   busy = (state==HOLD) | (drain!=0).
//  clear is only honoured in IDLE. Held through HOLD, it takes effect on the next IDLE.
//   It does not wait for the drain.
//  Async reset mid-op: valid_o drops immediately. Any op in flight is lost; the upstream
//   block re-issues it.
// TESTING (TOTAL_LEVEL=6)
//  Reset, then insert cnt=0x10, addr=0xABCDE -> in_ready=1 @T; @T+1 valid_o=1, opcode_o=0,
//   insert_path_o=1, index_o=0, heap_element_cnt_o=0; heap_count=1; valid_o=0 @T+2.
//  in_valid held for 10 inserts -> in_ready 1,0,1,0...; heap_element_cnt_o 0..9;
//   insert_path_o 1..10; heap_count=10.
//  Fill to 63 -> full=1, in_ready stays 0 with in_valid=1, no further insert valid_o.
//   query_req then still pulses valid_o with opcode_o=1.
//  query_req and in_valid in the same IDLE cycle -> query_ack=1, query op issued first;
//   the insert is accepted 2 cycles later.
//  heap_count=5, clear during HOLD -> applied in the next IDLE; heap_count=0; the next
//   insert has insert_path_o=1 and heap_element_cnt_o=0.
//  rst_n low during HOLD -> valid_o=0 and heap_count=0 immediately. After release,
//   busy=0 and in_ready=1.
//  Single op -> busy=1 for exactly 1+12 cycles from valid_o.

Source files
------------

// File: rtl/heap_insert_issuer.sv
// ============================================================================
// heap_insert_issuer
//   Issues insert/query ops to heap level 1 and paces them at one op per two
//   cycles. It tracks the heap element count and the drain window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_insert_issuer #(
  parameter int CNT_SIZE    = 20,
  parameter int ADDR_SIZE   = 28,
  parameter int TOTAL_LEVEL = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CNT_SIZE-1:0]    in_cnt,
  input  logic [ADDR_SIZE-1:0]   in_addr,
  input  logic                   query_req,
  output logic                   query_ack,
  input  logic                   clear,
  output logic                   valid_o,
  output logic                   opcode_o,
  output logic [CNT_SIZE-1:0]    wcnt_o,
  output logic [ADDR_SIZE-1:0]   waddr_o,
  output logic [TOTAL_LEVEL-1:0] insert_path_o,
  output logic [TOTAL_LEVEL-1:0] index_o,
  output logic [TOTAL_LEVEL-1:0] heap_element_cnt_o,
  output logic [TOTAL_LEVEL-1:0] heap_count,
  output logic                   full,
  output logic                   busy
);

  localparam logic [TOTAL_LEVEL-1:0] CAP        = {TOTAL_LEVEL{1'b1}};
  localparam int                     DRAIN_W    = $clog2(2*TOTAL_LEVEL+1);
  localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(2*TOTAL_LEVEL);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_do_clear;
  logic                 w_do_query;
  logic                 w_do_insert;
  logic [DRAIN_W-1:0]   r_drain;

  assign full = (heap_count == CAP);
  assign busy = (r_state == S_HOLD) || (r_drain != '0);

  // Priority in IDLE: clear, then query, then insert.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    query_ack   = 1'b0;
    w_do_clear  = 1'b0;
    w_do_query  = 1'b0;
    w_do_insert = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_do_clear = 1'b1;
        end else if (query_req) begin
          query_ack   = 1'b1;
          w_do_query  = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          in_ready    = !full;
          w_do_insert = in_valid && !full;
          if (w_do_insert) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers hold their last value while no op is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o            <= 1'b0;
      opcode_o           <= 1'b0;
      wcnt_o             <= '0;
      waddr_o            <= '0;
      insert_path_o      <= '0;
      index_o            <= '0;
      heap_element_cnt_o <= '0;
      heap_count         <= '0;
    end else begin
      valid_o  <= w_do_query || w_do_insert;
      opcode_o <= w_do_query;
      index_o  <= '0;
      if (w_do_clear) begin
        heap_count <= '0;
      end
      if (w_do_query) begin
        wcnt_o             <= '0;
        waddr_o            <= '0;
        heap_element_cnt_o <= heap_count;
      end
      if (w_do_insert) begin
        wcnt_o             <= in_cnt;
        waddr_o            <= in_addr;
        heap_element_cnt_o <= heap_count;
        insert_path_o      <= heap_count + 1'b1;
        heap_count         <= heap_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain <= '0;
    end else if (valid_o) begin
      r_drain <= DRAIN_LOAD;
    end else if (r_drain != '0) begin
      r_drain <= r_drain - 1'b1;
    end
  end

endmodule

`default_nettype wire
